// File: rtl/apb_slave_pkg.sv
// Shared types and defaults for the APB3 register-memory completer.
// Holds the FSM state enum and the address error check (alignment plus range).
package apb_slave_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Word-misaligned byte addresses and words past the end of the array both error.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_WIDTH word array, cleared by async reset, with a byte-strobed write port.
// Read is a plain index into the flopped array; the caller registers the result.
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [DATA_WIDTH-1:0]   wr_dat,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_dat
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_strb[b]) begin
                    mem_d[wr_idx][8*b +: 8] = wr_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer over a byte-strobed register memory with programmable wait states.
// Transfer takes wait_states+2 cycles; all outputs registered; PSEL drop aborts cleanly.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [3:0]              wait_states,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int STRB_W = DATA_WIDTH/8;
    localparam int IDX_W  = $clog2(DEPTH);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  err_q, err_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  wr_en;

    assign setup_err = addr_err(32'(PADDR), DEPTH);
    assign setup_idx = PADDR[IDX_W+1:2];
    // Zero-wait transfers need the read word at the setup edge, before the index is latched.
    assign rd_idx    = (state_q == IDLE) ? setup_idx : idx_q;

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (PCLK),
        .rst     (PRESET),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_strb (strb_q),
        .wr_dat  (wdat_q),
        .rd_idx  (rd_idx),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdat_d    = wdat_q;
        strb_d    = strb_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        wr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    idx_d   = setup_idx;
                    write_d = PWRITE;
                    wdat_d  = PWDATA;
                    strb_d  = PSTRB;
                    err_d   = setup_err;
                    cnt_d   = wait_states;
                    if (wait_states == 4'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = (!PWRITE && !setup_err) ? rd_dat : '0;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q) begin
                    if (PENABLE) begin
                        wr_en     = write_q && !err_q;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (!write_q && !err_q) ? rd_dat : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdat_q    <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdat_q    <= wdat_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed plus randomized APB transfers against a word-array reference model.
module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [3:0]  wait_states;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [32];
    logic [31:0] rd;

    always #5 PCLK = ~PCLK;

    apb_slave_mem dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .wait_states (wait_states),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rdy"},  {31'h0, PREADY},  32'h0);
        chk({tag, "_err"},  {31'h0, PSLVERR}, 32'h0);
        chk({tag, "_rdat"}, PRDATA,           32'h0);
    endtask

    // abort_kind: 0 none, 1 drop PSEL, 2 pulse PRESET; abort_at = access cycles completed before abort.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdat,
                        input logic [3:0] strb, input logic [3:0] ws,
                        input int abort_at, input int abort_kind, output logic [31:0] rdat);
        logic        e;
        logic [31:0] exp_rd;
        logic [31:0] word;
        e      = (addr[1:0] != 2'b00) || (addr >= 8'h80);
        exp_rd = (!wr && !e) ? mem_m[addr[6:2]] : 32'h0;
        rdat   = 32'h0;

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = wdat; PSTRB = strb; wait_states = ws;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR = 8'($urandom); PWDATA = $urandom; wait_states = 4'($urandom);

        for (int c = 0; c <= int'(ws); c++) begin
            if (abort_kind != 0 && c == abort_at) begin
                if (abort_kind == 1) begin
                    PSEL = 1'b0; PENABLE = 1'b0;
                    @(posedge PCLK); #1;
                    chk_outputs_zero("abort");
                end else begin
                    PRESET = 1'b1;
                    #1;
                    chk_outputs_zero("midrst");
                    PSEL = 1'b0; PENABLE = 1'b0;
                    @(posedge PCLK); #1;
                    PRESET = 1'b0;
                    clear_model();
                end
                return;
            end
            if (c < int'(ws)) begin
                chk("wait_rdy", {31'h0, PREADY},  32'h0);
                chk("wait_err", {31'h0, PSLVERR}, 32'h0);
            end else begin
                chk("rdy",   {31'h0, PREADY},  32'h1);
                chk("err",   {31'h0, PSLVERR}, {31'h0, e});
                chk("rdata", PRDATA,           exp_rd);
                rdat = PRDATA;
            end
            @(posedge PCLK); #1;
        end

        if (wr && !e) begin
            word = mem_m[addr[6:2]];
            for (int b = 0; b < 4; b++)
                if (strb[b]) word[8*b +: 8] = wdat[8*b +: 8];
            mem_m[addr[6:2]] = word;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        chk_outputs_zero("done");
    endtask

    initial begin
        logic        rw;
        logic [7:0]  ra;
        logic [3:0]  rws;
        int          kind;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h0; PWDATA = 32'h0; PSTRB = 4'h0; wait_states = 4'h0;
        clear_model();
        repeat (3) @(posedge PCLK);
        #1;
        chk_outputs_zero("reset");
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Zero-wait write then read back.
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 4'd0, 0, 0, rd);
        xfer(1'b0, 8'h10, 32'h0,        4'h0, 4'd0, 0, 0, rd);
        chk("raw_zero_wait", rd, 32'hDEADBEEF);

        // Three wait states on a read.
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 4'd3, 0, 0, rd);
        chk("read_ws3", rd, 32'hDEADBEEF);

        // Partial strobes.
        xfer(1'b1, 8'h10, 32'h11223344, 4'b0101, 4'd1, 0, 0, rd);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 4'd0, 0, 0, rd);
        chk("strb_merge", rd, 32'hDE22BE44);

        // Zero strobes change nothing.
        xfer(1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000, 4'd0, 0, 0, rd);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 4'd2, 0, 0, rd);
        chk("strb_none", rd, 32'hDE22BE44);

        // Error responses: out of range read, misaligned write.
        xfer(1'b0, 8'h84, 32'h0,        4'h0, 4'd0, 0, 0, rd);
        xfer(1'b1, 8'h13, 32'hCAFEF00D, 4'hF, 4'd2, 0, 0, rd);
        xfer(1'b0, 8'h10, 32'h0,        4'h0, 4'd0, 0, 0, rd);
        chk("err_no_write", rd, 32'hDE22BE44);
        xfer(1'b0, 8'h7C, 32'h0,        4'h0, 4'd0, 0, 0, rd);
        chk("last_word", rd, 32'h0);

        // PSEL dropped partway through a waited write.
        xfer(1'b1, 8'h10, 32'h55555555, 4'hF, 4'd5, 2, 1, rd);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 4'd0, 0, 0, rd);
        chk("abort_no_write", rd, 32'hDE22BE44);

        // Reset pulsed partway through a waited write clears memory.
        xfer(1'b1, 8'h10, 32'h55555555, 4'hF, 4'd5, 2, 2, rd);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 4'd0, 0, 0, rd);
        chk("rst_clears", rd, 32'h0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, 4'd1, 0, 0, rd);
        chk("rst_read04", rd, 32'h0);

        // Randomized traffic, back to back.
        for (int n = 0; n < 80; n++) begin
            rw   = 1'($urandom);
            rws  = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = 8'($urandom);
            else ra = {1'b0, 5'($urandom), 2'b00};
            kind = ($urandom_range(0, 15) == 0 && rws > 0) ? 1 : 0;
            xfer(rw, ra, $urandom, 4'($urandom), rws,
                 int'($urandom_range(0, 32'(rws))), kind, rd);
        end

        // Sweep every word to confirm final contents.
        for (int i = 0; i < 32; i++) begin
            xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, 4'd0, 0, 0, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
